frame_loader: RTL and testbench
===============================

Name: frame_loader

Overview:
- Writer end of the image RAM that the 2-D convolution engine reads.
- Accepts a raster-order 12-bit pixel stream over a valid/ready handshake and writes each pixel to RAM at address BASE_ADDR + row*COLS + col.
- After a full frame it starts the convolution engine, then waits for completion before accepting the next frame.

Parameters:
- COLS, 5, pixels per row.
- ROWS, 5, rows per frame.
- DATA_W, 12, pixel width.
- ADDR_W, 17, RAM address width.
- BASE_ADDR, 0, address of pixel (0,0).
- START_CYCLES, 2, number of cycles conv_start is held high.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  level; request to load a frame.
- s_valid  in  1  pixel valid.
- s_data  in  DATA_W  pixel value.
- s_last  in  1  marks the final pixel of the frame.
- s_ready  out  1  loader can accept a pixel.
- we  out  1  RAM write enable.
- addr_wr  out  ADDR_W  RAM write address.
- d_wr  out  DATA_W  RAM write data.
- conv_start  out  1  start request to the convolution engine.
- conv_done  in  1  completion level from the convolution engine.
- frame_done  out  1  one-cycle pulse when a frame has been fully processed.
- busy  out  1  high in any state other than IDLE.
- err_len  out  1  sticky frame-length error flag.

Behaviour:
- Reset applies to all state: we, addr_wr, d_wr, s_ready, conv_start, frame_done, busy, err_len = 0.
  - State returns to IDLE; row, col and the start counter are cleared.
  - Reset mid-frame discards the partial frame; no conv_start is issued.
- States: IDLE, LOAD, START, WAIT. All outputs are registered.
- IDLE:
  - s_ready=0.
  - arm=1 -> LOAD, with row=col=0 and err_len cleared.
- LOAD:
  - s_ready=1. A pixel is accepted on any cycle with s_valid && s_ready.
  - Accepted pixel: on the next cycle we=1, d_wr=s_data, addr_wr=BASE_ADDR+row*COLS+col. Write latency is 1 cycle.
  - we=0 on every cycle that follows a cycle with no acceptance.
  - The address is computed incrementally (+1 per pixel) without a multiplier. It is truncated to ADDR_W with no error check.
  - Counters: col increments per accepted pixel. At col==COLS-1 it wraps to 0 and row increments.
- Final pixel (row==ROWS-1 && col==COLS-1) accepted:
  - -> START; s_ready=0 from the next cycle.
  - If s_last=0 on that pixel, err_len=1, but the frame is still launched.
- Early s_last (s_last=1 on an accepted non-final pixel):
  - That pixel is still written.
  - err_len=1, state -> IDLE, no conv_start.
  - RAM contents are left partial.
- Gaps with s_valid low stall LOAD indefinitely; there is no timeout.
- START:
  - conv_start=1 for exactly START_CYCLES consecutive cycles, then -> WAIT.
  - The loader samples conv_done on its last START cycle into a prev register.
- WAIT:
  - Completion is a rising edge of conv_done: conv_done=1 with prev=0. prev updates every cycle.
  - A conv_done level already high on entry does not count as completion.
  - On completion: frame_done=1 for one cycle. Next state is LOAD (counters zeroed) if arm=1 on that cycle, else IDLE.
  - arm, s_valid and s_last are ignored in START and WAIT; s_ready stays 0.
- busy is high in LOAD, START and WAIT.
- err_len stays high until the next IDLE->LOAD transition or rst.

Test Plan:
- 5x5 frame, s_data=0x100+i for i=0..24, s_valid held high, s_last on i=24:
  - we on 25 consecutive cycles, addr_wr 0..24, d_wr = 0x100..0x118.
  - s_ready falls one cycle after i=24; conv_start high for 2 cycles; err_len=0.
- Same frame with s_valid toggled 1/0 every cycle:
  - 25 writes, each one cycle after its acceptance.
  - Addresses contiguous 0..24; we low on gap cycles.
- s_last asserted on pixel 7:
  - Writes at addresses 0..7; err_len=1; state returns to IDLE.
  - conv_start never rises; frame_done stays 0.
- 25 pixels with no s_last:
  - err_len=1; conv_start still pulses.
  - After a conv_done rise: frame_done pulses once.
- conv_done held high before WAIT, then driven 0 then 1:
  - frame_done pulses only after the 0->1 transition.
  - With arm=1 at that point, s_ready=1 on the next cycle and addr_wr restarts at 0.
- rst asserted after 12 accepted pixels:
  - Next cycle: all outputs 0, IDLE.
  - Re-arm and a full frame writes addresses from 0.

Source files
------------

// File: rtl/frame_loader.sv
// Writer side of the convolution image RAM: loads one raster frame, kicks the
// convolution engine, and waits for its completion edge before the next frame.
module frame_loader #(
  parameter int COLS         = 5,
  parameter int ROWS         = 5,
  parameter int DATA_W       = 12,
  parameter int ADDR_W       = 17,
  parameter int BASE_ADDR    = 0,
  parameter int START_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              we,
  output logic [ADDR_W-1:0] addr_wr,
  output logic [DATA_W-1:0] d_wr,
  output logic              conv_start,
  input  logic              conv_done,
  output logic              frame_done,
  output logic              busy,
  output logic              err_len
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW = $clog2(START_CYCLES + 1);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [CW-1:0]     COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0]     ROW_MAX = RW'(ROWS - 1);
  localparam logic [SW-1:0]     ST_MAX  = SW'(START_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

  state_t            state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [ADDR_W-1:0] addr_cnt;
  logic [SW-1:0]     st_cnt;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      addr_cnt   <= BASE;
      st_cnt     <= '0;
      prev       <= 1'b0;
      s_ready    <= 1'b0;
      we         <= 1'b0;
      addr_wr    <= '0;
      d_wr       <= '0;
      conv_start <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            state    <= LOAD;
            col      <= '0;
            row      <= '0;
            addr_cnt <= BASE;
            err_len  <= 1'b0;
            s_ready  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (s_valid && s_ready) begin
            we       <= 1'b1;
            d_wr     <= s_data;
            addr_wr  <= addr_cnt;
            addr_cnt <= addr_cnt + 1'b1;
            if (col == COL_MAX) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (row == ROW_MAX && col == COL_MAX) begin
              // a missing s_last is flagged, but the full frame still runs
              if (!s_last) err_len <= 1'b1;
              state      <= START;
              st_cnt     <= '0;
              s_ready    <= 1'b0;
              conv_start <= 1'b1;
            end else if (s_last) begin
              err_len <= 1'b1;
              state   <= IDLE;
              s_ready <= 1'b0;
              busy    <= 1'b0;
            end
          end
        end
        START: begin
          st_cnt <= st_cnt + 1'b1;
          if (st_cnt == ST_MAX) begin
            conv_start <= 1'b0;
            prev       <= conv_done;
            state      <= WAIT;
          end
        end
        WAIT: begin
          prev <= conv_done;
          // only a fresh 0->1 edge counts; a level held from before is ignored
          if (conv_done && !prev) begin
            frame_done <= 1'b1;
            if (arm) begin
              state    <= LOAD;
              col      <= '0;
              row      <= '0;
              addr_cnt <= BASE;
              s_ready  <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_loader.sv
// Bench for frame_loader: directed frames plus randomized traffic, every cycle
// checked against a pixel-index level model of the loader.
module tb_frame_loader;
  localparam int COLS = 5, ROWS = 5, DATA_W = 12, ADDR_W = 17, BASE_ADDR = 0, START_CYCLES = 2;
  localparam int NPIX = COLS * ROWS;

  logic clk = 1'b0, rst = 1'b1, arm = 1'b0, s_valid = 1'b0, s_last = 1'b0, conv_done = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic s_ready, we, conv_start, frame_done, busy, err_len;
  logic [ADDR_W-1:0] addr_wr;
  logic [DATA_W-1:0] d_wr;

  frame_loader #(.COLS(COLS), .ROWS(ROWS), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                 .BASE_ADDR(BASE_ADDR), .START_CYCLES(START_CYCLES)) dut (
    .clk(clk), .rst(rst), .arm(arm), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .we(we), .addr_wr(addr_wr), .d_wr(d_wr), .conv_start(conv_start),
    .conv_done(conv_done), .frame_done(frame_done), .busy(busy), .err_len(err_len));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 loading, 2 starting, 3 waiting.
  int phase = 0, idx = 0, scnt = 0;
  bit m_prev = 0, m_on = 0;
  bit e_we = 0, e_fd = 0, e_err = 0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [DATA_W-1:0] e_d = '0;

  always @(posedge clk) begin
    if (rst) begin
      phase = 0; idx = 0; scnt = 0; m_prev = 0; m_on = 1;
      e_we = 0; e_fd = 0; e_err = 0; e_addr = '0; e_d = '0;
    end else begin
      e_we = 0; e_fd = 0;
      case (phase)
        0: if (arm) begin phase = 1; idx = 0; e_err = 0; end
        1: if (s_valid) begin
             e_we = 1; e_d = s_data;
             e_addr = ADDR_W'(BASE_ADDR + idx);
             if (idx == NPIX - 1) begin
               if (!s_last) e_err = 1;
               phase = 2; scnt = 0;
             end else if (s_last) begin
               e_err = 1; phase = 0;
             end else idx++;
           end
        2: begin
             scnt++;
             if (scnt == START_CYCLES) begin m_prev = conv_done; phase = 3; end
           end
        default: begin
             if (conv_done && !m_prev) begin
               e_fd = 1; idx = 0;
               phase = arm ? 1 : 0;
             end
             m_prev = conv_done;
           end
      endcase
    end
  end

  // Per-cycle compare plus event counters used by the literal checks.
  int n_we = 0, n_cs = 0, n_fd = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [DATA_W-1:0] last_d = '0;
  always @(negedge clk) begin
    if (m_on) begin
      chk("we", we, e_we);
      chk("addr_wr", addr_wr, e_addr);
      chk("d_wr", d_wr, e_d);
      chk("s_ready", s_ready, phase == 1);
      chk("conv_start", conv_start, phase == 2);
      chk("frame_done", frame_done, e_fd);
      chk("busy", busy, phase != 0);
      chk("err_len", err_len, e_err);
    end
    if (we) begin n_we++; last_addr = addr_wr; last_d = d_wr; end
    if (conv_start) n_cs++;
    if (frame_done) n_fd++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic arm_pulse();
    arm = 1; tick(); arm = 0;
  endtask

  // gap: 0 none, 1 alternate, 2 random. last_at = -1 means no s_last.
  task automatic send(input int npix, input int last_at, input int gap, input int base_d);
    int i = 0;
    while (i < npix) begin
      if (gap == 0 || (gap == 1 && s_valid == 0) || (gap == 2 && $urandom_range(0, 2) != 0)) begin
        s_valid = 1; s_data = DATA_W'(base_d + i); s_last = (i == last_at); i++;
      end else begin
        s_valid = 0; s_last = $urandom_range(0, 1); s_data = DATA_W'($urandom);
      end
      tick();
    end
    s_valid = 0; s_last = 0;
  endtask

  task automatic done_pulse(input bit arm_at);
    conv_done = 0; tick(); conv_done = 1; arm = arm_at; tick(); arm = 0; conv_done = 0; tick();
  endtask

  int w0, c0, f0;
  task automatic mark();
    w0 = n_we; c0 = n_cs; f0 = n_fd;
  endtask

  initial begin
    tick(2);
    rst = 0;
    chk("reset_busy", busy, 0);
    chk("reset_ready", s_ready, 0);

    // 1: back-to-back full frame
    mark(); arm_pulse();
    send(NPIX, NPIX - 1, 0, 'h100);
    chk("f1_ready_low", s_ready, 0);
    tick(4);
    chk("f1_writes", n_we - w0, 25);
    chk("f1_last_addr", last_addr, 24);
    chk("f1_last_data", last_d, 'h118);
    chk("f1_cs_cycles", n_cs - c0, 2);
    chk("f1_err", err_len, 0);
    done_pulse(0);
    chk("f1_fd", n_fd - f0, 1);

    // 2: alternating valid
    mark(); arm_pulse();
    send(NPIX, NPIX - 1, 1, 'h200);
    tick(4);
    chk("f2_writes", n_we - w0, 25);
    chk("f2_last_addr", last_addr, 24);
    done_pulse(0);

    // 3: early s_last on pixel 7
    mark(); arm_pulse();
    send(8, 7, 0, 'h300);
    tick(3);
    chk("f3_writes", n_we - w0, 8);
    chk("f3_last_addr", last_addr, 7);
    chk("f3_err", err_len, 1);
    chk("f3_busy", busy, 0);
    done_pulse(0);
    chk("f3_cs", n_cs - c0, 0);
    chk("f3_fd", n_fd - f0, 0);

    // 4: full frame without s_last
    mark(); arm_pulse();
    chk("f4_err_cleared", err_len, 0);
    send(NPIX, -1, 0, 'h400);
    tick(4);
    chk("f4_err", err_len, 1);
    chk("f4_cs", n_cs - c0, 2);
    done_pulse(0);
    chk("f4_fd", n_fd - f0, 1);

    // 5: conv_done high before WAIT, then 0 -> 1 with arm held
    mark(); arm_pulse();
    conv_done = 1;
    send(NPIX, NPIX - 1, 0, 'h500);
    tick(5);
    chk("f5_no_fd_on_level", n_fd - f0, 0);
    conv_done = 0; tick();
    conv_done = 1; arm = 1; tick();
    arm = 0; conv_done = 0;
    chk("f5_fd", n_fd - f0, 1);
    chk("f5_ready", s_ready, 1);
    mark();
    send(1, -1, 0, 'h5a0);
    tick();
    chk("f5_restart_addr", last_addr, 0);
    send(NPIX - 1, NPIX - 2, 0, 'h5a1);
    tick(4);
    done_pulse(0);

    // 6: reset after 12 pixels
    arm_pulse();
    send(12, -1, 0, 'h600);
    rst = 1; tick(); rst = 0;
    chk("f6_rst_we", we, 0);
    chk("f6_rst_addr", addr_wr, 0);
    chk("f6_rst_busy", busy, 0);
    chk("f6_rst_ready", s_ready, 0);
    mark(); arm_pulse();
    send(NPIX, NPIX - 1, 2, 'h700);
    tick(4);
    chk("f6_writes", n_we - w0, 25);
    chk("f6_last_addr", last_addr, 24);
    chk("f6_cs", n_cs - c0, 2);
    done_pulse(0);

    // 7: randomized traffic, model checks every cycle
    for (int k = 0; k < 40; k++) begin
      int r, la;
      r = $urandom_range(0, 9);
      la = (r < 6) ? NPIX - 1 : (r < 8) ? $urandom_range(0, NPIX - 2) : -1;
      if ($urandom_range(0, 1)) arm_pulse();
      conv_done = $urandom_range(0, 1);
      send((la >= 0) ? la + 1 : NPIX, la, $urandom_range(0, 2), $urandom);
      tick($urandom_range(0, 4));
      done_pulse($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin rst = 1; tick(); rst = 0; end
    end
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
